// File: rtl/rv32i_types.sv
// Shared front-end types: the IF/ID payload and the fetch FSM encoding.
package rv32i_types;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ORDER_W = 64;
  localparam int unsigned RMASK_W = 4;

  localparam logic [RMASK_W-1:0] RMASK_ALL  = 4'b1111;
  localparam logic [RMASK_W-1:0] RMASK_NONE = 4'b0000;

  typedef struct packed {
    logic [XLEN-1:0]    inst;
    logic [XLEN-1:0]    pc;
    logic [ORDER_W-1:0] order;
    logic               valid;
  } if_id_stage_reg_t;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetched instructions; flush beats push and pop.
module fetch_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  if_id_stage_reg_t         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output if_id_stage_reg_t         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if_id_stage_reg_t   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Head is read straight from storage so decode sees no path from the inputs.
  assign o_head = o_empty ? '0 : r_mem[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns pc/order, runs one imem request at a time, queues returned
// instructions for decode and flushes younger state on redirect.
module fetch_unit
  import rv32i_types::*;
#(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic [63:0]      redirect_order,
  input  logic             decode_ready,
  output if_id_stage_reg_t if_id_out,
  output logic             queue_full
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t     r_state;
  fetch_state_t     w_next_state;
  logic [31:0]      r_pc;
  logic [31:0]      w_next_pc;
  logic [63:0]      r_order;
  logic [63:0]      w_next_order;
  logic [31:0]      r_imem_addr;
  logic [3:0]       r_imem_rmask;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  if_id_stage_reg_t w_push_data;
  if_id_stage_reg_t w_head;

  assign w_push_data = '{inst: imem_rdata, pc: r_pc, order: r_order, valid: 1'b1};
  assign w_pop       = !w_empty && decode_ready && !redirect_valid;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Next-state logic; a redirect overrides whatever the state would have done.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_order = r_order;
    w_push       = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        if (w_count < CNT_W'(QUEUE_DEPTH)) w_next_state = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_resp) begin
          w_push       = 1'b1;
          w_next_pc    = r_pc + 32'd4;
          w_next_order = r_order + 64'd1;
          w_next_state = FETCH_IDLE;
        end
      end
      FETCH_DISCARD: begin
        if (imem_resp) w_next_state = FETCH_IDLE;
      end
      default: w_next_state = FETCH_IDLE;
    endcase
    if (redirect_valid) begin
      w_push       = 1'b0;
      w_next_pc    = redirect_pc;
      w_next_order = redirect_order;
      if ((r_state != FETCH_IDLE) && !imem_resp) w_next_state = FETCH_DISCARD;
      else                                       w_next_state = FETCH_IDLE;
    end
  end

  // Address tracks pc while idle and freezes for the life of a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH_IDLE;
      r_pc         <= RESET_PC;
      r_order      <= '0;
      r_imem_addr  <= RESET_PC;
      r_imem_rmask <= RMASK_NONE;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_order      <= w_next_order;
      r_imem_addr  <= (w_next_state == FETCH_IDLE) ? w_next_pc : r_imem_addr;
      r_imem_rmask <= (w_next_state == FETCH_IDLE) ? RMASK_NONE : RMASK_ALL;
    end
  end

  assign imem_addr  = r_imem_addr;
  assign imem_rmask = r_imem_rmask;
  assign if_id_out  = w_head;
  assign queue_full = w_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + random bench for fetch_unit against a transaction-level queue model.
module tb_fetch_unit;
  import rv32i_types::*;

  localparam int unsigned QD       = 8;
  localparam logic [31:0] RST_PC   = 32'h1eceb000;

  logic             clk;
  logic             rst_n;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic [31:0]      imem_rdata;
  logic             imem_resp;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [63:0]      redirect_order;
  logic             decode_ready;
  if_id_stage_reg_t if_id_out;
  logic             queue_full;

  fetch_unit #(.QUEUE_DEPTH(QD), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_order (redirect_order),
    .decode_ready   (decode_ready),
    .if_id_out      (if_id_out),
    .queue_full     (queue_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: expected queue contents plus architectural pc/order.
  if_id_stage_reg_t exp_q[$];
  if_id_stage_reg_t popped_q[$];
  if_id_stage_reg_t last_push;
  logic [31:0]      m_pc;
  logic [63:0]      m_order;
  bit               stale;
  int               n_acc;
  int               mem_cnt;
  int               mem_lat;
  bit               rand_lat;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    popped_q.delete();
    m_pc    = RST_PC;
    m_order = 64'd0;
    stale   = 1'b0;
    mem_cnt = 0;
  endtask

  // One clock cycle: called just after a falling edge, returns after the next one.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc,
                       input logic [63:0] rord);
    if_id_stage_reg_t e;
    decode_ready   = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    redirect_order = rord;
    imem_resp      = 1'b0;
    if (imem_rmask == 4'hF) begin
      if (mem_cnt >= mem_lat) begin
        imem_resp  = 1'b1;
        imem_rdata = $urandom;
        mem_cnt    = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else begin
        mem_cnt++;
      end
    end
    #1;
    chk("valid", 160'(if_id_out.valid), 160'(exp_q.size() != 0));
    chk("queue_full", 160'(queue_full), 160'(exp_q.size() == QD));
    if (if_id_out.valid && rdy && !redir && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("head", 160'(if_id_out), 160'(e));
      popped_q.push_back(e);
    end
    if (imem_resp && !redir && !stale) begin
      chk("req_addr", 160'(imem_addr), 160'(m_pc));
      e = '{inst: imem_rdata, pc: m_pc, order: m_order, valid: 1'b1};
      exp_q.push_back(e);
      last_push = e;
      n_acc++;
      m_pc    = m_pc + 32'd4;
      m_order = m_order + 64'd1;
    end else if (imem_resp) begin
      stale = 1'b0;
    end
    if (redir) begin
      exp_q.delete();
      m_pc    = rpc;
      m_order = rord;
      stale   = (imem_rmask == 4'hF) && !imem_resp;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    int guard;
    bit reached;
    logic [31:0] rnd;
    logic [31:0] rpc;
    logic [63:0] rord;

    rst_n = 1'b0; imem_rdata = '0; imem_resp = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; redirect_order = '0; decode_ready = 1'b0;
    n_acc = 0; mem_lat = 0; rand_lat = 1'b0; last_push = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_rmask", 160'(imem_rmask), 160'(4'h0));
    chk("rst_addr", 160'(imem_addr), 160'(RST_PC));
    chk("rst_ifid", 160'(if_id_out), 160'(0));
    chk("rst_full", 160'(queue_full), 160'(0));
    rst_n = 1'b1;

    // Steady fetch: contiguous pc/order through several pointer wraps.
    for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, '0, '0);
    chk("p1_entries", 160'(popped_q.size() >= 20), 160'(1));
    for (int i = 0; i < popped_q.size(); i++) begin
      chk("p1_pc", 160'(popped_q[i].pc), 160'(RST_PC + 32'(4 * i)));
      chk("p1_order", 160'(popped_q[i].order), 160'(i));
    end

    // Back-pressure: queue fills and no request issues until one pop.
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, '0, '0);
    chk("p2_full", 160'(queue_full), 160'(1));
    chk("p2_rmask", 160'(imem_rmask), 160'(4'h0));
    n0 = n_acc;
    cycle(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, '0);
    chk("p2_one_more", 160'(n_acc - n0), 160'(1));
    chk("p2_full_again", 160'(queue_full), 160'(1));

    // Redirect while a request is outstanding: stale response must be dropped.
    mem_lat = 3;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0, '0);
    guard = 0;
    while (imem_rmask !== 4'hF && guard < 20) begin cycle(1'b1, 1'b0, '0, '0); guard++; end
    chk("p3_in_wait", 160'(imem_rmask), 160'(4'hF));
    cycle(1'b1, 1'b1, 32'h1eceb100, 64'd57);
    n0 = n_acc; guard = 0;
    while (n_acc == n0 && guard < 30) begin cycle(1'b1, 1'b0, '0, '0); guard++; end
    chk("p3_push_seen", 160'(n_acc > n0), 160'(1));
    chk("p3_pc", 160'(last_push.pc), 160'(32'h1eceb100));
    chk("p3_order", 160'(last_push.order), 160'(57));

    // Redirect coinciding with a response: no push, next request at redirect_pc.
    mem_lat = 2; guard = 0;
    while (!(imem_rmask == 4'hF && mem_cnt >= mem_lat) && guard < 20) begin
      cycle(1'b1, 1'b0, '0, '0); guard++;
    end
    n0 = n_acc;
    cycle(1'b1, 1'b1, 32'h1eceb200, 64'd100);
    chk("p4_no_push", 160'(n_acc), 160'(n0));
    chk("p4_idle_rmask", 160'(imem_rmask), 160'(4'h0));
    chk("p4_idle_addr", 160'(imem_addr), 160'(32'h1eceb200));
    cycle(1'b1, 1'b0, '0, '0);
    chk("p4_req_rmask", 160'(imem_rmask), 160'(4'hF));
    chk("p4_req_addr", 160'(imem_addr), 160'(32'h1eceb200));

    // Async reset mid-request with three queued entries.
    mem_lat = 5;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0, '0);
    reached = 1'b0; guard = 0;
    while (!reached && guard < 80) begin
      if (exp_q.size() == 3 && imem_rmask == 4'hF) reached = 1'b1;
      else begin cycle(1'b0, 1'b0, '0, '0); guard++; end
    end
    chk("p6_reached", 160'(reached), 160'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("p6_rmask", 160'(imem_rmask), 160'(4'h0));
    chk("p6_addr", 160'(imem_addr), 160'(RST_PC));
    chk("p6_ifid", 160'(if_id_out), 160'(0));
    chk("p6_full", 160'(queue_full), 160'(0));
    imem_resp = 1'b0;
    model_reset();
    mem_lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, '0, '0);
    chk("p6_restart", 160'(popped_q.size() > 0), 160'(1));
    if (popped_q.size() > 0) begin
      chk("p6_pc0", 160'(popped_q[0].pc), 160'(RST_PC));
      chk("p6_order0", 160'(popped_q[0].order), 160'(0));
    end

    // Random traffic with redirects, including pc/order wrap-around targets.
    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rnd  = $urandom;
      rpc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {rnd[31:2], 2'b00};
      rord = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc, rord);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage. Owns the PC and the commit-order counter, issues one instruction-memory read at a time, and buffers returned instructions in an in-order queue. Presents the queue head to `decode` as an `if_id_stage_reg_t` under a valid/ready handshake. Branch and jump redirects from the back end flush all younger state.

## Interface
- `QUEUE_DEPTH`, 8: instruction-queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h1eceb000: PC after reset.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  32: word-aligned fetch address.
- `imem_rmask`  out  4: 4'b1111 while a request is outstanding, else 0.
- `imem_rdata`  in  32: returned instruction, qualified by `imem_resp`.
- `imem_resp`  in  1: one-cycle response pulse.
- `redirect_valid`  in  1: flush request from commit or branch resolution.
- `redirect_pc`  in  32: new fetch PC; bits [1:0] are 0.
- `redirect_order`  in  64: order number assigned to the first instruction fetched at `redirect_pc`.
- `decode_ready`  in  1: downstream accepts the head entry this cycle.
- `if_id_out`  out  `if_id_stage_reg_t`: {inst, pc, order, valid}. `valid` = queue not empty.
- `queue_full`  out  1: count == QUEUE_DEPTH (debug/perf).

## Operation
- State: `pc`[31:0], `order`[63:0], queue (head ptr, tail ptr, count of width log2(QUEUE_DEPTH)+1), FSM.
- FSM states:
  - IDLE: if count < QUEUE_DEPTH, go to WAIT and drive the request.
  - WAIT: request outstanding. On `imem_resp`, push {imem_rdata, pc, order, 1}, set pc += 4 and order += 1, then return to IDLE.
  - DISCARD: stale request outstanding after a redirect. On `imem_resp`, drop the data and go to IDLE.
- While in WAIT or DISCARD: `imem_addr` is held stable and `imem_rmask` = 4'b1111. In IDLE: `imem_rmask` = 0 and `imem_addr` = pc.
- Only one request is outstanding at a time. Issue is gated on count < QUEUE_DEPTH, and count cannot grow between issue and response, so a response never meets a full queue.
- Pop when `if_id_out.valid && decode_ready`: head += 1, count -= 1.
- Push and pop in the same cycle leave count unchanged.
- Redirect has priority over everything else in its cycle:
  - queue emptied (head = tail, count = 0); any pop that cycle is ignored;
  - pc ← redirect_pc, order ← redirect_order;
  - FSM: WAIT without a same-cycle resp → DISCARD; WAIT with a same-cycle resp → IDLE, data dropped; DISCARD with a same-cycle resp → IDLE; otherwise → IDLE.
- A redirect arriving while already in DISCARD updates pc/order and stays in DISCARD, unless resp is present that cycle.
- Pointers wrap modulo QUEUE_DEPTH. `pc` and `order` wrap naturally at 2^32 and 2^64.

## Timing
- Reset values: pc = RESET_PC, order = 0, count/head/tail = 0, FSM = IDLE, `imem_rmask` = 0, `imem_addr` = RESET_PC, `if_id_out` = '0 (valid 0), `queue_full` = 0.
- Reset asserted mid-request abandons the request. Memory is reset by the same `rst_n`.
- Request issue: the request is visible in the cycle after IDLE is entered with space available. Back-to-back fetch gives one response per two cycles at minimum (resp → IDLE → WAIT).
- Fill latency: `imem_resp` at edge N → entry on `if_id_out` with valid = 1 after edge N.
- Pop is visible next cycle: the new head, or valid = 0.
- `if_id_out` is combinational from queue storage and head pointer only; no combinational path from `imem_*` or `decode_ready`.
- Redirect at edge N: `if_id_out.valid` = 0 after N. A new request for redirect_pc appears no earlier than cycle N+2, or after the stale response is dropped.

## Structure
- `if_id_stage_reg_t` and the fetch FSM enum `fetch_state_t` go in `rv32i_types`.
- One sub-module, `fetch_queue`: parameterised circular FIFO with push, pop, flush, full, empty and count.
- The FSM, pc and order logic live in `fetch_unit`.

## Test plan
- Reset then steady fetch, `decode_ready` = 1, resp 1 cycle after each request: entries pc 0x1eceb000, 0x1eceb004, 0x1eceb008 with order 0, 1, 2, in sequence.
- `decode_ready` = 0 with fast memory: after 8 pushes `queue_full` = 1 and `imem_rmask` stays 0. One pop lets exactly one more request issue.
- Redirect to 0x1eceb100 with order 57 while WAIT, resp 3 cycles later: that response is dropped. The next pushed entry has pc 0x1eceb100, order 57; queue empty in between.
- Redirect in the same cycle as `imem_resp`: no push, FSM goes to IDLE, next request addr = redirect_pc.
- Simultaneous push and pop at count 4: count stays 4 and head advances. Fill past the pointer wrap over 20 entries: order values stay contiguous.
- `rst_n` asserted low while WAIT with 3 queued entries: outputs return immediately to reset values without a clock edge. After release, fetch restarts at RESET_PC with order 0.
